// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the 5x5 convolution frame scheduler
package conv_pkg;
  localparam int K = 5;
  localparam int K_LB = K - 1;
  typedef logic signed [7:0] pixel_t;
  typedef logic signed [7:0] weight_t;
  typedef logic signed [31:0] acc_t;
  typedef pixel_t [K-1:0][K-1:0] window_t;
  typedef enum logic [1:0] {IDLE, LOAD_W, RUN, DRAIN} sched_state_t;
endpackage

// File: rtl/conv_result_fifo.sv
// conv_result_fifo: sync FIFO (clk, rst_n, push/din, pop/dout, empty, count); dout reads 0 when empty
module conv_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign empty = count == '0;
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/conv_frame_scheduler.sv
// conv_frame_scheduler: loads 25 weights, windows a raster pixel stream, returns datapath results via credited FIFO
module conv_frame_scheduler
  import conv_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int CONV_LAT = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    start,
  output logic    busy,
  output logic    done,
  input  logic    w_valid,
  output logic    w_ready,
  input  weight_t w_data,
  input  logic    px_valid,
  output logic    px_ready,
  input  pixel_t  px_data,
  output window_t conv_window,
  output window_t conv_weights,
  input  acc_t    conv_result,
  output logic    res_valid,
  input  logic    res_ready,
  output acc_t    res_data,
  output logic    res_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int TOTAL = (IMG_H - 4) * (IMG_W - 4);
  localparam int OW = $clog2(TOTAL + 1);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  sched_state_t state;
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic [2:0] wi, wj;
  logic [OW-1:0] out_cnt;
  logic issue_q;
  logic [CONV_LAT-1:0] pipe;
  pixel_t lb [K_LB][IMG_W];
  pixel_t col [K];
  logic [FW-1:0] fifo_count;
  logic fifo_empty, credit_ok, w_acc, px_acc, pop;
  int inflight;
  always_comb begin
    inflight = int'(issue_q);
    for (int i = 0; i < CONV_LAT; i++) inflight = inflight + int'(pipe[i]);
    credit_ok = int'(fifo_count) + inflight < FIFO_DEPTH;
    for (int i = 0; i < K_LB; i++) col[i] = lb[i][c];
    col[K_LB] = px_data;
  end
  assign busy = state != IDLE;
  assign w_ready = state == LOAD_W;
  assign px_ready = state == RUN && credit_ok;
  assign w_acc = w_valid && w_ready;
  assign px_acc = px_valid && px_ready;
  assign res_valid = !fifo_empty;
  assign pop = res_valid && res_ready;
  assign res_last = res_valid && out_cnt == OW'(TOTAL - 1);
  // Line buffer column c is a 4-deep vertical shift: index 0 holds row r-4, index 3 row r-1.
  always_ff @(posedge clk)
    if (px_acc) begin
      for (int i = 0; i < K_LB - 1; i++) lb[i][c] <= lb[i+1][c];
      lb[K_LB-1][c] <= px_data;
    end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      c <= '0;
      r <= '0;
      wi <= '0;
      wj <= '0;
      out_cnt <= '0;
      issue_q <= 1'b0;
      pipe <= '0;
      conv_window <= '0;
      conv_weights <= '0;
    end else begin
      done <= 1'b0;
      // Rows 0..3 never issue, so stale line-buffer rows from an earlier frame are never seen.
      issue_q <= px_acc && r >= RW'(K_LB) && c >= CW'(K_LB);
      pipe <= {pipe[CONV_LAT-2:0], issue_q};
      if (pop) out_cnt <= out_cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= LOAD_W;
          c <= '0;
          r <= '0;
          wi <= '0;
          wj <= '0;
          out_cnt <= '0;
        end
        LOAD_W: if (w_acc) begin
          conv_weights[wi][wj] <= w_data;
          wj <= wj == 3'(K - 1) ? '0 : wj + 1'b1;
          wi <= wj == 3'(K - 1) ? wi + 1'b1 : wi;
          if (wi == 3'(K - 1) && wj == 3'(K - 1)) state <= RUN;
        end
        RUN: if (px_acc) begin
          // Newest column enters at index K-1; older columns move toward index 0.
          for (int i = 0; i < K; i++) conv_window[i] <= {col[i], conv_window[i][K-1:1]};
          c <= c == C_LAST ? '0 : c + 1'b1;
          r <= c == C_LAST ? r + 1'b1 : r;
          if (r == R_LAST && c == C_LAST) state <= DRAIN;
        end
        DRAIN: if (pop && res_last) begin
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  conv_result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pipe[CONV_LAT-1]),
    .din   (conv_result),
    .pop   (pop),
    .dout  (res_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_conv_frame_scheduler.sv
// tb_conv_frame_scheduler: randomized frames checked against a plain-arithmetic convolution model
module tb_conv_frame_scheduler;
  import conv_pkg::*;
  localparam int W = 32;
  localparam int H = 32;
  localparam int TOTAL = (W - 4) * (H - 4);
  logic clk = 0, rst_n = 0, start = 0, busy, done;
  logic w_valid = 0, w_ready, px_valid = 0, px_ready;
  weight_t w_data = 0;
  pixel_t px_data = 0;
  window_t conv_window, conv_weights;
  acc_t conv_result, res_data;
  logic res_valid, res_ready = 0, res_last;
  int n_chk = 0, n_fail = 0;
  int img [H][W];
  int wt [25];
  int exp_q [$];
  int mphase = 0, wcnt = 0, pxcnt = 0, prod = 0, pops = 0;
  bit done_exp = 0, after_rst = 0, pop_now, hold = 0;
  int unsigned rdy_pct = 70;
  logic [31:0] first_res, last_res;
  int d1, d2, d3, e;
  always #5 clk = ~clk;
  conv_frame_scheduler #(.IMG_W(W), .IMG_H(H), .CONV_LAT(3), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
    .conv_window(conv_window), .conv_weights(conv_weights), .conv_result(conv_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last)
  );
  function automatic int dot(input window_t a, input window_t b);
    int s = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) s += int'($signed(a[i][j])) * int'($signed(b[i][j]));
    return s;
  endfunction
  // Three-stage datapath stand-in: result for the window shown at cycle t appears at t+3.
  always @(posedge clk) begin
    d1 <= dot(conv_window, conv_weights);
    d2 <= d1;
    d3 <= d2;
  end
  assign conv_result = d3;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, $signed(act), $signed(req));
    end
  endtask
  task automatic summary;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
  endtask
  task automatic bail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL timeout %s: got no response required a response", nm);
    summary();
    $finish;
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    res_ready = !hold && ($urandom_range(99) < rdy_pct);
  end
  // Cycle model: checks outputs, then advances by the inputs seen at the coming edge.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(mphase != 0));
    chk("w_ready", 32'(w_ready), 32'(mphase == 1));
    chk("px_ready", 32'(px_ready), 32'(mphase == 2 && prod - pops < 8));
    chk("done", 32'(done), 32'(done_exp));
    if (after_rst) begin
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_window", 32'(|conv_window), 0);
      chk("rst_weights", 32'(|conv_weights), 0);
    end
    chk("res_last", 32'(res_last), 32'(res_valid && pops == TOTAL - 1));
    pop_now = res_valid && res_ready;
    if (pop_now) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_result: got %0d required no result", res_data);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", res_data, 32'(e));
      end
      if (pops == 0) first_res = res_data;
      last_res = res_data;
      pops++;
    end
    done_exp = 0;
    after_rst = 0;
    if (!rst_n) begin
      mphase = 0;
      exp_q.delete();
      after_rst = 1;
    end else case (mphase)
      0: if (start) begin
        mphase = 1;
        wcnt = 0;
        pxcnt = 0;
        prod = 0;
        pops = 0;
      end
      1: if (w_valid && w_ready && ++wcnt == 25) mphase = 2;
      2: if (px_valid && px_ready) begin
        if (pxcnt / W >= 4 && pxcnt % W >= 4) prod++;
        if (++pxcnt == W * H) mphase = 3;
      end
      3: if (pop_now && pops == TOTAL) begin
        mphase = 0;
        done_exp = 1;
      end
      default: mphase = 0;
    endcase
  end
  task automatic setup(input int mode);
    for (int k = 0; k < 25; k++)
      wt[k] = mode == 0 ? 1 : mode == 1 ? int'(k == 12) : mode == 2 ? -128 : int'($urandom_range(255)) - 128;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = mode == 0 ? 1 : mode == 1 ? (r * 32 + c) % 128 : mode == 2 ? -128 : int'($urandom_range(255)) - 128;
    for (int i = 0; i < H - 4; i++)
      for (int j = 0; j < W - 4; j++) begin
        int s = 0;
        for (int a = 0; a < 5; a++)
          for (int b = 0; b < 5; b++) s += img[i+a][j+b] * wt[a*5+b];
        exp_q.push_back(s);
      end
  endtask
  task automatic send(input bit is_px, input logic [7:0] d);
    bit ok = 0;
    while ($urandom_range(3) == 0) begin
      @(posedge clk);
      #1;
    end
    if (is_px) begin
      px_valid = 1;
      px_data = d;
    end else begin
      w_valid = 1;
      w_data = d;
    end
    for (int n = 0; n < 5000 && !ok; n++) begin
      start = $urandom_range(7) == 0;
      @(negedge clk);
      ok = is_px ? px_ready : w_ready;
      @(posedge clk);
      #1;
    end
    start = 0;
    px_valid = 0;
    w_valid = 0;
    if (!ok) bail(is_px ? "pixel_handshake" : "weight_handshake");
  endtask
  task automatic send_pixels(input int npx);
    for (int p = 0; p < npx; p++) send(1, 8'(img[p / W][p % W]));
  endtask
  task automatic hold_ctl;
    bit hit = 0;
    for (int n = 0; n < 4000 && !hit; n++) begin
      @(posedge clk);
      #2;
      hit = mphase == 2 && prod - pops >= 8;
    end
    if (!hit) bail("credit_fill");
    chk("hold_blocked", 32'(px_ready), 0);
    repeat (100) @(posedge clk);
    #2;
    chk("hold_still_blocked", 32'(px_ready), 0);
    chk("hold_res_valid", 32'(res_valid), 1);
    chk("hold_no_pops", 32'(pops), 0);
    hold = 0;
  endtask
  task automatic run_frame(input int npx, input bit hold_test);
    bit got = 0;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    for (int k = 0; k < 25; k++) send(0, 8'(wt[k]));
    if (hold_test) fork
      send_pixels(npx);
      hold_ctl();
    join
    else send_pixels(npx);
    if (npx == W * H) begin
      for (int n = 0; n < 20000 && !got; n++) begin
        @(posedge clk);
        #2;
        got = done;
      end
      if (!got) bail("done");
      chk("frame_pops", 32'(pops), TOTAL);
      chk("frame_leftover", 32'(exp_q.size()), 0);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    setup(0);
    run_frame(W * H, 0);
    chk("ones_first", first_res, 25);
    chk("ones_last", last_res, 25);
    setup(1);
    run_frame(W * H, 0);
    chk("center_first", first_res, 66);
    chk("center_last", last_res, 61);
    rdy_pct = 100;
    setup(2);
    run_frame(W * H, 0);
    chk("neg_first", first_res, 32'sh00064000);
    chk("neg_last", last_res, 32'sh00064000);
    rdy_pct = 50;
    setup(3);
    hold = 1;
    run_frame(W * H, 1);
    setup(3);
    run_frame(300, 0);
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_px_ready", 32'(px_ready), 0);
    chk("rst_res_last", 32'(res_last), 0);
    setup(3);
    run_frame(W * H, 0);
    repeat (5) @(posedge clk);
    summary();
    $finish;
  end
endmodule

// File: doc/conv_frame_scheduler.md
Name: conv_frame_scheduler

Overview:
- Sequences the 5x5 three-stage MAC datapath over one feature map per start pulse.
- Loads 25 weights from a stream, then accepts a raster-order pixel stream.
- Builds 5x5 windows using a 4-row line buffer and a window shift register, and issues one window per valid output position.
- Tracks datapath latency and returns results through a credit-protected output FIFO with valid/ready backpressure.

Parameters:
- IMG_W, 32, pixels per input row (>=5)
- IMG_H, 32, rows per input frame (>=5)
- CONV_LAT, 3, cycles from window issue to conv_result valid (matches the datapath)
- FIFO_DEPTH, 8, output FIFO entries (power of 2, >= CONV_LAT+1)

Ports:
- clk, in, 1, clock
- rst_n, in, 1, synchronous active-low reset
- start, in, 1, one-cycle frame start; ignored unless IDLE
- busy, out, 1, high in any state except IDLE
- done, out, 1, one-cycle pulse when the last result is popped
- w_valid/w_ready, in/out, 1/1, weight stream handshake
- w_data, in, 8, signed weight, row-major (k = i*5+j)
- px_valid/px_ready, in/out, 1/1, pixel stream handshake
- px_data, in, 8, signed pixel, raster order
- conv_window, out, 5x5x8, signed window to datapath
- conv_weights, out, 5x5x8, signed weights to datapath (held constant)
- conv_result, in, 32, signed datapath result
- res_valid/res_ready, out/in, 1/1, result stream handshake
- res_data, out, 32, signed result
- res_last, out, 1, high with the final result of the frame

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE.
  - Outputs reset to 0: busy, done, w_ready, px_ready, res_valid, res_last.
  - conv_window, conv_weights and res_data reset to 0.
  - Row/col/weight counters, FIFO pointers/count and issue pipeline are all cleared.
  - Reset mid-frame discards all in-flight data; no done pulse is generated.
- IDLE: start=1 moves to LOAD_W.
- LOAD_W:
  - w_ready=1.
  - Each accepted weight is written to index w_cnt; w_cnt increments.
  - On the 25th accept, move to RUN.
- RUN: px_ready = credit_ok, where credit_ok = (fifo_count + inflight) < FIFO_DEPTH.
  - inflight counts the issue_q bit plus all set bits in the CONV_LAT pipe.
  - On a pixel accept at (r,c):
    - Write the line buffer.
    - Shift window columns left; the new column is {lb[r-4..r-1][c], px_data}.
    - Advance c, wrapping to 0 at IMG_W-1 and incrementing r.
  - If r>=4 and c>=4, set issue_q the next cycle.
    - conv_window then holds the window for output (r-4,c-4).
    - Push a valid bit into a CONV_LAT-deep shift pipe.
  - When the pipe output is 1, push conv_result into the FIFO that cycle.
    - A push never overflows; this is guaranteed by credits.
  - Accepting pixel (IMG_H-1,IMG_W-1) moves to DRAIN.
- DRAIN:
  - px_ready=0.
  - Wait until the FIFO is empty and inflight=0 with the final pop done.
  - Then pulse done, go IDLE.
- Output side:
  - res_valid = !fifo_empty; res_data = FIFO head.
  - Pop on res_valid & res_ready.
  - Simultaneous push and pop in one cycle keeps the count unchanged.
  - res_last is high when the head is result number (IMG_H-4)*(IMG_W-4) of the frame; tracked by an output counter.
- Widths:
  - Data is carried transparently; no arithmetic is performed on results.
  - Counters are sized $clog2(IMG_W), $clog2(IMG_H) and $clog2((IMG_H-4)*(IMG_W-4)+1).
- Other boundaries:
  - start while busy is ignored.
  - w_valid outside LOAD_W and px_valid outside RUN are not accepted.
  - Line buffer data from the previous frame is never used: no issue occurs while r<4.

Decomposition:
- Package conv_pkg:
  - K=5 and K_LB=K-1
  - pixel_t (logic signed [7:0]), weight_t (logic signed [7:0]), acc_t (logic signed [31:0])
  - window_t (pixel_t [K-1:0][K-1:0])
  - sched_state_t enum {IDLE, LOAD_W, RUN, DRAIN}
- Sub-module conv_result_fifo: synchronous FIFO with parameters DEPTH and WIDTH=32, exporting count.
- Line buffer and window register stay in the top module.

Test Plan:
- All weights 1, 32x32 image of all 1:
  - exactly 784 results of 25;
  - res_last only on the 784th;
  - done one cycle after that pop.
- Weight 1 at k=12, others 0; pixel value = (r*32+c) mod 128 as signed:
  - result n (position (i,j)) equals pixel (i+2,j+2).
- All weights -128, all pixels -128: every result is 409600 (32'sh00064000).
- Hold res_ready=0 during RUN:
  - px_ready drops once FIFO count + inflight reaches 8;
  - release after 100 cycles → all 784 results are delivered in order, none lost or duplicated.
- Assert rst_n=0 for 1 cycle mid-RUN:
  - all outputs are 0 and the state is IDLE;
  - a new start plus full frame gives a correct 784-result frame with no stale data.
- start pulsed during LOAD_W and RUN: ignored; weight count and result count are unchanged.
